fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_write_arbiter_rr_picker.sv | 27 ++
 rtl/fifo_write_arbiter.sv | 88 ++++++++
 tb/tb_fifo_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and default sizes for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rtl/fifo_write_arbiter_rr_picker.sv - stateless rotate-priority search starting at ptr
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any_valid
);

  logic [IDW-1:0] cand;

  // Scan farthest-first so the requester nearest to ptr is written last and wins.
  always_comb begin
    idx       = ptr;
    cand      = '0;
    any_valid = |valid;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (valid[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin packet arbiter feeding one FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [DATA_WIDTH-1:0]         fifo_data_out,
  output logic                          fifo_write_en_out,
  input  logic                          fifo_full_in,
  output logic [ID_WIDTH-1:0]           grant_id_out,
  output logic                          locked_out
);

  arb_state_t          state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_nxt;
  logic [ID_WIDTH-1:0] owner, owner_nxt;
  logic [ID_WIDTH-1:0] pick_idx, winner, winner_inc;
  logic                any_valid, active, xfer, win_last;

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_picker (
    .valid     (req_valid_in),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  assign winner     = (state == LOCKED) ? owner : pick_idx;
  assign winner_inc = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_WIDTH'(1);
  assign active     = (state == LOCKED) || any_valid;
  assign win_last   = req_last_in[winner];
  // Outputs are forced quiet for the whole reset window, not just after the edge.
  assign xfer       = req_valid_in[winner] && !fifo_full_in && !rst;

  assign req_ready_out     = (!rst && !fifo_full_in && active) ? (NUM_REQ'(1) << winner) : '0;
  assign fifo_write_en_out = xfer;
  assign fifo_data_out     = xfer ? req_data_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id_out      = rst ? '0 : winner;
  assign locked_out        = !rst && (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      owner  <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    if (xfer) begin
      case (state)
        ARB: begin
          if (win_last) begin
            rr_nxt = winner_inc;
          end else begin
            state_nxt = LOCKED;
            owner_nxt = winner;
          end
        end
        LOCKED: begin
          if (win_last) begin
            state_nxt = ARB;
            rr_nxt    = winner_inc;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter with a queue-based FIFO
module tb_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid_in;
  logic [NR*DW-1:0] req_data_in;
  logic [NR-1:0] req_last_in;
  logic [NR-1:0] req_ready_out;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_write_en_out;
  logic          fifo_full_in;
  logic [1:0]    grant_id_out;
  logic          locked_out;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_in      (req_valid_in),
    .req_data_in       (req_data_in),
    .req_last_in       (req_last_in),
    .req_ready_out     (req_ready_out),
    .fifo_data_out     (fifo_data_out),
    .fifo_write_en_out (fifo_write_en_out),
    .fifo_full_in      (fifo_full_in),
    .grant_id_out      (grant_id_out),
    .locked_out        (locked_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level reference: who holds the FIFO (-1 = nobody) and whose turn is next.
  int m_owner;
  int m_rr;

  logic [DW-1:0] fq[$];
  logic          force_full;

  logic [NR-1:0] s_ready;
  logic          s_we;
  logic [DW-1:0] s_data;
  logic [1:0]    s_gid;
  logic          s_locked;

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    last;
    logic             full;
    logic [NR-1:0]    exp_ready;
    logic             exp_we;
    logic [DW-1:0]    exp_data;
    logic [1:0]       exp_gid;
    logic             exp_locked;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int m_winner(input logic [NR-1:0] v);
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < NR; k++) begin
      if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
    end
    return m_rr;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic [NR-1:0] l);
    int w;
    logic full;
    logic [NR-1:0] e_ready;
    logic e_we;
    logic [DW-1:0] e_data;
    full = force_full || (fq.size() >= FIFO_DEPTH);
    req_valid_in = v;
    req_data_in  = d;
    req_last_in  = l;
    fifo_full_in = full;
    #1;
    w       = m_winner(v);
    e_we    = v[w] && !full;
    e_ready = (!full && (m_owner >= 0 || v != '0)) ? NR'(1 << w) : '0;
    e_data  = e_we ? d[w*DW +: DW] : '0;
    s_ready = req_ready_out;
    s_we    = fifo_write_en_out;
    s_data  = fifo_data_out;
    s_gid   = grant_id_out;
    s_locked = locked_out;
    chk("model_ready", 32'(s_ready), 32'(e_ready));
    chk("model_we", 32'(s_we), 32'(e_we));
    chk("model_data", 32'(s_data), 32'(e_data));
    chk("model_gid", 32'(s_gid), 32'(w));
    chk("model_locked", 32'(s_locked), 32'(m_owner >= 0));
    @(posedge clk);
    if (s_we) fq.push_back(s_data);
    if (e_we) begin
      if (l[w]) begin
        m_owner = -1;
        m_rr    = (w + 1) % NR;
      end else begin
        m_owner = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    if (fq.size() == 0) begin
      chk({name, "_empty"}, 32'(0), 32'(1));
    end else begin
      got = fq.pop_front();
      chk(name, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    int cnt55;
    logic [DW-1:0] beat;
    force_full   = 1'b0;
    rst          = 1'b1;
    req_valid_in = '1;
    req_data_in  = 32'hDEADBEEF;
    req_last_in  = '0;
    fifo_full_in = 1'b0;
    model_reset();

    // Reset-state outputs while requests are already offered.
    #2;
    chk("rst_ready", 32'(req_ready_out), 32'h0);
    chk("rst_we", 32'(fifo_write_en_out), 32'h0);
    chk("rst_data", 32'(fifo_data_out), 32'h0);
    chk("rst_gid", 32'(grant_id_out), 32'h0);
    chk("rst_locked", 32'(locked_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // valid data last full | ready we data gid locked
    vecs.push_back('{4'b0001, 32'h00000011, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b0});
    vecs.push_back('{4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0});
    vecs.push_back('{4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0});
    vecs.push_back('{4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0});
    vecs.push_back('{4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0});
    vecs.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0});
    vecs.push_back('{4'b0010, 32'h00002100, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b0});
    vecs.push_back('{4'b0100, 32'h002F0000, 4'b0100, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b1});
    vecs.push_back('{4'b0110, 32'h002F2200, 4'b0100, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1});
    vecs.push_back('{4'b0110, 32'h002F2300, 4'b0110, 1'b0, 4'b0010, 1'b1, 8'h23, 2'd1, 1'b1});
    vecs.push_back('{4'b0100, 32'h002F0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h2F, 2'd2, 1'b0});

    foreach (vecs[i]) begin
      force_full = vecs[i].full;
      step(vecs[i].valid, vecs[i].data, vecs[i].last);
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_data", i), 32'(s_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_gid", i), 32'(s_gid), 32'(vecs[i].exp_gid));
      chk($sformatf("vec%0d_locked", i), 32'(s_locked), 32'(vecs[i].exp_locked));
    end
    force_full = 1'b0;
    pop_chk("order0", 8'h11);
    pop_chk("order1", 8'hA1);
    pop_chk("order2", 8'hA2);
    pop_chk("order3", 8'hA3);
    pop_chk("order4", 8'h21);
    pop_chk("order5", 8'h22);
    pop_chk("order6", 8'h23);
    pop_chk("order7", 8'h2F);

    // Full backpressure: fill the FIFO, then offer 0x55 until one slot frees.
    fq.delete();
    for (int i = 0; i < FIFO_DEPTH; i++) step(4'b0001, 32'(i), 4'b0001);
    chk("fill_size", 32'(fq.size()), 32'(FIFO_DEPTH));
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 32'h00005500, 4'b0010);
      chk("full_ready", 32'(s_ready), 32'h0);
      chk("full_we", 32'(s_we), 32'h0);
    end
    pop_chk("full_pop", 8'h00);
    step(4'b0010, 32'h00005500, 4'b0010);
    chk("unfull_we", 32'(s_we), 32'h1);
    step(4'b0000, 32'h0, 4'b0000);
    cnt55 = 0;
    foreach (fq[i]) if (fq[i] == 8'h55) cnt55++;
    chk("full_end_size", 32'(fq.size()), 32'(FIFO_DEPTH));
    chk("full_55_once", 32'(cnt55), 32'h1);
    chk("full_55_tail", 32'(fq[$]), 32'h55);

    // Owner stall: req3 locks, goes idle, req0 must wait.
    fq.delete();
    step(4'b1000, 32'h31000000, 4'b0000);
    chk("stall_lock_we", 32'(s_we), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 32'h00000005, 4'b0001);
      chk("stall_r0_ready", 32'(s_ready[0]), 32'h0);
      chk("stall_locked", 32'(s_locked), 32'h1);
    end
    step(4'b1001, 32'h32000005, 4'b1001);
    chk("stall_resume_data", 32'(s_data), 32'h32);
    step(4'b0001, 32'h00000005, 4'b0001);
    chk("stall_r0_gid", 32'(s_gid), 32'h0);
    chk("stall_r0_ready_after", 32'(s_ready), 32'h1);
    pop_chk("stall_o0", 8'h31);
    pop_chk("stall_o1", 8'h32);
    pop_chk("stall_o2", 8'h05);

    // Reset in the middle of a lock: outputs drop at once, arbiter restarts fresh.
    step(4'b0010, 32'h00004400, 4'b0000);
    chk("rl_locked_pre", 32'(dut.locked_out), 32'h1);
    req_valid_in = 4'b0110;
    req_data_in  = 32'h00777700;
    #2;
    rst = 1'b1;
    #1;
    chk("rl_ready", 32'(req_ready_out), 32'h0);
    chk("rl_we", 32'(fifo_write_en_out), 32'h0);
    chk("rl_data", 32'(fifo_data_out), 32'h0);
    chk("rl_gid", 32'(grant_id_out), 32'h0);
    chk("rl_locked", 32'(locked_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b0000, 32'h0, 4'b0000);
    chk("rl_rr_zero", 32'(s_gid), 32'h0);
    chk("rl_arb", 32'(s_locked), 32'h0);
    step(4'b0100, 32'h00660000, 4'b0100);
    chk("rl_r2_gid", 32'(s_gid), 32'h2);
    chk("rl_r2_ready", 32'(s_ready), 32'h4);

    // Randomised traffic against the reference model.
    fq.delete();
    for (int i = 0; i < 400; i++) begin
      force_full = ($urandom_range(0, 4) == 0);
      if (fq.size() > 0 && $urandom_range(0, 2) == 0) beat = fq.pop_front();
      step(NR'($urandom), $urandom, NR'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
